seq_gen_tx: RTL and testbench

Serial pattern transmitter: the source side of the serial bit-sequence stream consumed by the team's sequence detectors. It loads a programmable bit pattern of 1..MAXLEN bits and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times with an optional run of idle bits between repetitions. It drives the detector's `xin` input in loopback and benches, and serves as the serial stimulus source in the top-level design.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_down_cnt.sv | 35 +++
 rtl/seq_gen_tx.sv | 174 +++++++++++++++++
 tb/tb_seq_gen_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding for the serial sequence generator and detectors
package seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP,
        S_DONE  = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/seq_down_cnt.sv
// rtl/seq_down_cnt.sv - loadable down-counter that holds at zero
module seq_down_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = din;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/seq_gen_tx.sv
// rtl/seq_gen_tx.sv - serial pattern transmitter, MSB-first with repeats and idle gaps
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter int MAXLEN = 8,
    parameter int REPW   = 4,
    parameter int GAPW   = 3,
    localparam int LENW  = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LENW-1:0]   len,
    input  logic [REPW-1:0]   reps,
    input  logic [GAPW-1:0]   gap,
    output logic              xout,
    output logic              xvalid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_e        state_q, state_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [MAXLEN-1:0] work_q, work_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [GAPW-1:0]   gap_q, gap_d;
    logic              xout_q, xout_d;
    logic              xvalid_q, xvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              idx_load, idx_en, idx_zero;
    logic [LENW-1:0]   idx_din;
    logic              rep_load, rep_en, rep_zero;
    logic              gap_load, gap_en, gap_zero;
    logic              len_ok, abort_now;

    assign len_ok    = (len != '0) && (len <= LENW'(MAXLEN));
    assign abort_now = abort && ((state_q == S_SHIFT) || (state_q == S_GAP));

    // The shadow pattern is stored left-aligned so the current bit is always the MSB of work_q.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        work_d   = work_q;
        len_d    = len_q;
        gap_d    = gap_q;
        idx_load = 1'b0;
        idx_en   = 1'b0;
        idx_din  = len_q - LENW'(1);
        rep_load = 1'b0;
        rep_en   = 1'b0;
        gap_load = 1'b0;
        gap_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && len_ok) begin
                    pat_d    = pattern << (LENW'(MAXLEN) - len);
                    work_d   = pattern << (LENW'(MAXLEN) - len);
                    len_d    = len;
                    gap_d    = gap;
                    idx_din  = len - LENW'(1);
                    idx_load = 1'b1;
                    rep_load = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!idx_zero) begin
                    idx_en = 1'b1;
                    work_d = work_q << 1;
                end else if (rep_zero) begin
                    state_d = S_DONE;
                end else if (gap_q != '0) begin
                    rep_en   = 1'b1;
                    gap_load = 1'b1;
                    state_d  = S_GAP;
                end else begin
                    rep_en   = 1'b1;
                    idx_load = 1'b1;
                    work_d   = pat_q;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_zero) begin
                    idx_load = 1'b1;
                    work_d   = pat_q;
                    state_d  = S_SHIFT;
                end else begin
                    gap_en = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state; an abort clears them on the same edge.
    always_comb begin
        xvalid_d = (state_q == S_SHIFT) && !abort_now;
        xout_d   = xvalid_d && work_q[MAXLEN-1];
        busy_d   = (state_q != S_IDLE) && !abort_now;
        done_d   = (state_q == S_DONE);
        err_d    = (state_q == S_IDLE) && start && !len_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            work_q   <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            xout_q   <= 1'b0;
            xvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            work_q   <= work_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            xout_q   <= xout_d;
            xvalid_q <= xvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    seq_down_cnt #(.WIDTH(LENW)) u_idx_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (idx_load),
        .en    (idx_en),
        .din   (idx_din),
        .zero  (idx_zero)
    );

    seq_down_cnt #(.WIDTH(REPW)) u_rep_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (rep_load),
        .en    (rep_en),
        .din   (reps),
        .zero  (rep_zero)
    );

    seq_down_cnt #(.WIDTH(GAPW)) u_gap_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (gap_load),
        .en    (gap_en),
        .din   (gap_q - GAPW'(1)),
        .zero  (gap_zero)
    );

    assign xout   = xout_q;
    assign xvalid = xvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb/tb_seq_gen_tx.sv - scoreboard bench for seq_gen_tx with a list-based reference model
module tb_seq_gen_tx;

    localparam int MAXLEN = 8;
    localparam int REPW   = 4;
    localparam int GAPW   = 3;
    localparam int LENW   = $clog2(MAXLEN + 1);
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [MAXLEN-1:0] pattern = '0;
    logic [LENW-1:0]   len = '0;
    logic [REPW-1:0]   reps = '0;
    logic [GAPW-1:0]   gap = '0;
    logic              xout, xvalid, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    seq_gen_tx #(.MAXLEN(MAXLEN), .REPW(REPW), .GAPW(GAPW)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .xout    (xout),
        .xvalid  (xvalid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic pop_chk(input string name, input int act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected output %0d with empty scoreboard at %0t", name, act, $time);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    // Monitor: every visible bit, done or err event is matched against the scoreboard.
    always @(negedge clk) begin
        if (xvalid) pop_chk("xout_bit", int'(xout));
        else chk("xout_zero_when_invalid", int'(xout), 0);
        if (done) pop_chk("done_event", EV_DONE);
        if (err) pop_chk("err_event", EV_ERR);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_model(input logic [MAXLEN-1:0] p, input int l, input int r);
        for (int k = 0; k <= r; k++)
            for (int i = l - 1; i >= 0; i--)
                exp_q.push_back(int'(p[i]));
    endtask

    task automatic run_tx(input logic [MAXLEN-1:0] p, input int l, input int r, input int g,
                          input bit disturb, input bit with_abort);
        int  cyc;
        bit  seen;
        int  tl;
        push_model(p, l, r);
        exp_q.push_back(EV_DONE);
        tl = (r + 1) * l + r * g;
        pattern = p;
        len     = LENW'(l);
        reps    = REPW'(r);
        gap     = GAPW'(g);
        start   = 1'b1;
        abort   = with_abort;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            step();
            cyc++;
            if (cyc == 1) begin
                start   = 1'b0;
                abort   = 1'b0;
                chk("busy_low_after_start_edge", int'(busy), 0);
                pattern = MAXLEN'($urandom);
                len     = LENW'($urandom);
                reps    = REPW'($urandom);
                gap     = GAPW'($urandom);
            end
            if (cyc == 2) begin
                chk("busy_rise", int'(busy), 1);
                chk("first_bit_valid", int'(xvalid), 1);
            end
            if (disturb && cyc == 3) begin
                start   = 1'b1;
                pattern = MAXLEN'($urandom);
                len     = LENW'(0);
            end
            if (disturb && cyc == 4) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk("done_latency", cyc, tl + 2);
        step();
        chk("busy_fall", int'(busy), 0);
    endtask

    task automatic run_err(input int l);
        exp_q.push_back(EV_ERR);
        len     = LENW'(l);
        pattern = MAXLEN'($urandom);
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("err_busy_stays_low", int'(busy), 0);
        chk("err_pulse_high", int'(err), 1);
        step();
        chk("err_pulse_one_cycle", int'(err), 0);
        chk("err_busy_low_later", int'(busy), 0);
    endtask

    task automatic run_abort(input logic [MAXLEN-1:0] p, input int l);
        exp_q.push_back(int'(p[l-1]));
        exp_q.push_back(int'(p[l-2]));
        pattern = p;
        len     = LENW'(l);
        reps    = REPW'(0);
        gap     = GAPW'(0);
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_xvalid_low", int'(xvalid), 0);
        repeat (6) step();
        chk("abort_no_pending", exp_q.size(), 0);
    endtask

    task automatic run_reset_mid();
        logic [MAXLEN-1:0] p;
        p = 8'b1011_0110;
        exp_q.push_back(int'(p[5]));
        exp_q.push_back(int'(p[4]));
        exp_q.push_back(int'(p[3]));
        pattern = p;
        len     = LENW'(6);
        reps    = REPW'(1);
        gap     = GAPW'(2);
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_xout", int'(xout), 0);
        chk("rst_xvalid", int'(xvalid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("rst_idle_busy", int'(busy), 0);
        chk("rst_no_pending", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_xout", int'(xout), 0);
        chk("reset_xvalid", int'(xvalid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        rst_n = 1'b1;
        step();

        run_tx(8'b0000_0101, 3, 0, 0, 1'b0, 1'b0);
        run_tx(8'b0000_0101, 3, 2, 1, 1'b0, 1'b0);
        run_tx(8'b0000_0010, 2, 3, 0, 1'b0, 1'b0);
        run_err(0);
        run_tx(8'hA5, MAXLEN, 0, 0, 1'b0, 1'b0);
        run_err(9);
        run_err(15);
        run_tx(8'h5C, 7, 1, 3, 1'b0, 1'b1);
        run_abort(8'b0001_0110, 5);
        run_tx(8'b0001_0110, 5, 0, 0, 1'b0, 1'b0);
        run_tx(8'hC3, MAXLEN, 1, 2, 1'b1, 1'b0);
        run_reset_mid();
        run_tx(8'h96, MAXLEN, 1, 7, 1'b0, 1'b0);
        run_tx(8'h01, 1, 0, 0, 1'b0, 1'b0);
        run_tx(8'h01, 1, 15, 0, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            run_tx(MAXLEN'($urandom), int'($urandom_range(1, MAXLEN)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
        end

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
